// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder path.
//   FFT_N / FFT_DW / FFT_LOG2N : default frame size, sample width, log2(frame size)
//   cplx_t                     : one complex sample, real part in the upper half
//   bitrev()                   : reverse the low log2n bits of an index
package fft_pkg;

  localparam int FFT_N     = 4;
  localparam int FFT_DW    = 12;
  localparam int FFT_LOG2N = 2;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  // Shift bits out of the bottom of k and into the bottom of r, so the
  // LSB of k ends up in bit position log2n-1 of the result.
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int unsigned log2n);
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    s = k;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(log2n)) begin
        r = {r[30:0], s[0]};
        s = s >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame buffer for the bit-reversal reorder stage.
//   clk                    : write clock
//   we, wr_bank, wr_addr   : synchronous write strobe and location (bank + index)
//   wr_data                : packed {re, im} sample
//   rd_bank, rd_addr       : asynchronous read location
//   rd_data                : packed {re, im} sample at the read location
// Contents are deliberately not reset; every location is written before it is read.
module fft_pingpong_ram
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int W     = 2 * FFT_DW
) (
  input  logic             clk,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [LOG2N-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_bank,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem [2*N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders each N-point frame from bit-reversed to natural index order.
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid, in_r, in_i : next input sample, frames arrive in bit-reversed order
//   out_valid, out_first : natural-order output beat, out_first marks X[0]
//   out_r, out_i         : output sample, passed through bit-exact
//
// Handshake: there is no ready in either direction. A sample is taken on every
// rising edge where in_valid=1, and the consumer must take every beat on which
// out_valid=1. A frame replays as N back-to-back beats, starting on the edge
// after its last sample is written.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int DW    = FFT_DW,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  output logic                 out_first,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic [LOG2N-1:0] rd_cnt;
  logic             rd_bank;
  logic             rd_active;
  logic [LOG2N-1:0] rd_addr;
  logic [2*DW-1:0]  rd_data;
  logic             frame_done;

  assign frame_done = in_valid && (wr_cnt == LAST);
  assign rd_addr    = LOG2N'(bitrev(32'(rd_cnt), LOG2N));

  fft_pingpong_ram #(
    .N     (N),
    .LOG2N (LOG2N),
    .W     (2 * DW)
  ) u_ram (
    .clk     (clk),
    .we      (in_valid),
    .wr_bank (wr_bank),
    .wr_addr (wr_cnt),
    .wr_data ({in_r, in_i}),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Write side: wr_cnt wraps naturally because N is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (in_valid) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (frame_done) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Read side. A completing frame takes priority over the end of the current
  // replay so that continuous input yields continuous output. The bank just
  // filled is always the one not being written next, so reads and writes never
  // touch the same bank while rd_active is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt    <= '0;
      rd_bank   <= 1'b0;
      rd_active <= 1'b0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      if (rd_active) begin
        out_r     <= rd_data[2*DW-1:DW];
        out_i     <= rd_data[DW-1:0];
        out_valid <= 1'b1;
        out_first <= (rd_cnt == '0);
        rd_cnt    <= rd_cnt + 1'b1;
        if (rd_cnt == LAST) begin
          rd_active <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
      end

      if (frame_done) begin
        rd_bank   <= wr_bank;
        rd_active <= 1'b1;
        rd_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: one N=4 and one N=8 instance, scoreboard
// queues filled by a frame-level reference model, and a negedge monitor.
module tb_fft_bitrev_reorder;

  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst;

  logic                 v4, ov4, of4;
  logic signed [DW-1:0] r4, i4, or4, oi4;
  logic                 v8, ov8, of8;
  logic signed [DW-1:0] r8, i8, or8, oi8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2*DW:0]   exp4_q[$];
  logic [2*DW:0]   exp8_q[$];
  logic [2*DW-1:0] buf4[$];
  logic [2*DW-1:0] buf8[$];

  bit prev4 = 1'b0, prev8 = 1'b0;
  int run4 = 0, last_run4 = 0;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.N(4), .DW(DW), .LOG2N(2)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_r(r4), .in_i(i4),
    .out_valid(ov4), .out_first(of4), .out_r(or4), .out_i(oi4)
  );

  fft_bitrev_reorder #(.N(8), .DW(DW), .LOG2N(3)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_r(r8), .in_i(i8),
    .out_valid(ov8), .out_first(of8), .out_r(or8), .out_i(oi8)
  );

  // ---------------- reference model ----------------
  function automatic int ref_bitrev(input int k, input int bits);
    int r;
    r = 0;
    for (int b = 0; b < bits; b++) r = r * 2 + (k / (1 << b)) % 2;
    return r;
  endfunction

  // Input position j holds natural index ref_bitrev(j); emit natural order.
  task automatic model_push(input bit big, input logic [2*DW-1:0] s);
    int n, bits;
    n    = big ? 8 : 4;
    bits = big ? 3 : 2;
    if (big) buf8.push_back(s); else buf4.push_back(s);
    if ((big ? buf8.size() : buf4.size()) == n) begin
      for (int k = 0; k < n; k++) begin
        for (int j = 0; j < n; j++) begin
          if (ref_bitrev(j, bits) == k) begin
            if (big) exp8_q.push_back({k == 0, buf8[j]});
            else     exp4_q.push_back({k == 0, buf4[j]});
          end
        end
      end
      if (big) buf8.delete(); else buf4.delete();
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " ov4"}, 32'(ov4), 0);
    check({tag, " of4"}, 32'(of4), 0);
    check({tag, " or4/oi4"}, 32'({or4, oi4}), 0);
    check({tag, " ov8"}, 32'(ov8), 0);
    check({tag, " of8"}, 32'(of8), 0);
    check({tag, " or8/oi8"}, 32'({or8, oi8}), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [2*DW:0] e;
    if (rst) begin
      prev4 = 1'b0; prev8 = 1'b0; run4 = 0;
    end else begin
      if (ov4) begin
        if (exp4_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL n4 unexpected beat: got %h expected none", {of4, or4, oi4});
        end else begin
          e = exp4_q.pop_front();
          check("n4 beat", 32'({of4, or4, oi4}), 32'(e));
        end
        if (!of4) check("n4 contiguous", 32'(prev4), 1);
        run4++;
      end else if (prev4) begin
        last_run4 = run4;
        run4 = 0;
      end
      prev4 = ov4;

      if (ov8) begin
        if (exp8_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL n8 unexpected beat: got %h expected none", {of8, or8, oi8});
        end else begin
          e = exp8_q.pop_front();
          check("n8 beat", 32'({of8, or8, oi8}), 32'(e));
        end
        if (!of8) check("n8 contiguous", 32'(prev8), 1);
      end
      prev8 = ov8;
    end
  end

  // ---------------- drivers ----------------
  task automatic clear_model();
    exp4_q.delete(); exp8_q.delete(); buf4.delete(); buf8.delete();
  endtask

  // Called just after a rising edge; asserts rst mid-cycle.
  task automatic do_reset(input string tag);
    v4 = 1'b0; v8 = 1'b0;
    #2 rst = 1'b1;
    clear_model();
    #1 check_outputs_zero(tag);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input bit big, input logic signed [DW-1:0] re,
                      input logic signed [DW-1:0] im, input int gap);
    if (big) begin v8 = 1'b1; r8 = re; i8 = im; end
    else     begin v4 = 1'b1; r4 = re; i4 = im; end
    model_push(big, {re, im});
    @(posedge clk); #1;
    v4 = 1'b0; v8 = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_t2(input int gap);
    send(0, 12'sd10, -12'sd1, gap);
    send(0, 12'sd30, -12'sd3, gap);
    send(0, 12'sd20, -12'sd2, gap);
    send(0, 12'sd40, -12'sd4, 0);
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 80; c++) begin
      if (exp4_q.size() == 0 && exp8_q.size() == 0) break;
      @(posedge clk);
    end
    check({tag, " drained"}, 32'(exp4_q.size() + exp8_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic signed [DW-1:0] rnd();
    return DW'($urandom_range(0, (1 << DW) - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic signed [DW-1:0] nat_re[8];
    logic signed [DW-1:0] nat_im[8];

    rst = 1'b1; v4 = 1'b0; v8 = 1'b0;
    r4 = '0; i4 = '0; r8 = '0; i8 = '0;
    #1 check_outputs_zero("power-up reset");
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // T2: single frame, plus first-beat latency.
    send_t2(0);
    @(posedge clk);
    @(negedge clk);
    check("t2 latency valid", 32'(ov4), 1);
    check("t2 latency first", 32'(of4), 1);
    check("t2 latency data", 32'({or4, oi4}), 32'({12'sd10, -12'sd1}));
    wait_drain("t2");

    // T1: reset asserted mid-replay clears outputs asynchronously.
    for (int k = 0; k < 4; k++)
      send(0, DW'($urandom_range(1, 2047)), DW'($urandom_range(1, 2047)), 0);
    @(posedge clk);
    #1;
    do_reset("t1 mid-replay");
    for (int k = 0; k < 3; k++) begin
      send(0, rnd(), rnd(), 2);
      check("t1 no early valid", 32'(ov4), 0);
    end
    send(0, rnd(), rnd(), 0);
    wait_drain("t1");

    // T3: three back-to-back random frames give 12 continuous beats.
    for (int k = 0; k < 12; k++) send(0, rnd(), rnd(), 0);
    wait_drain("t3");
    check("t3 continuous run", 32'(last_run4), 12);

    // T4: T2 with 3-cycle bubbles, then random frames with random bubbles.
    send_t2(3);
    wait_drain("t4");
    check("t4 run length", 32'(last_run4), 4);
    for (int k = 0; k < 12; k++) send(0, rnd(), rnd(), $urandom_range(0, 3));
    wait_drain("t4 random");

    // T5: partial frame discarded by reset.
    send(0, 12'sd99, 12'sd98, 0);
    send(0, 12'sd97, 12'sd96, 0);
    do_reset("t5 reset");
    send_t2(0);
    wait_drain("t5");

    // T6: N=8 extremes, fed in bit-reversed order.
    nat_re = '{-12'sd2048, 12'sd2047, 12'sd0, -12'sd2048, 12'sd2047, 12'sd0, 12'sd1, -12'sd1};
    nat_im = '{12'sd2047, 12'sd0, -12'sd2048, 12'sd0, -12'sd2048, 12'sd2047, -12'sd1, 12'sd5};
    for (int j = 0; j < 8; j++)
      send(1, nat_re[ref_bitrev(j, 3)], nat_im[ref_bitrev(j, 3)], 0);
    wait_drain("t6");
    for (int k = 0; k < 24; k++) send(1, rnd(), rnd(), $urandom_range(0, 1));
    wait_drain("t6 random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
